// File: rtl/simd_sequencer_if.sv
// Control, instruction-fetch, operand-read and result-write signals of the SIMD sequencer.
// master = sequencer side, slave = PS / BRAM / PE environment side.
interface simd_sequencer_if #(
  parameter int ADDR_WIDTH     = 10,
  parameter int INS_ADDR_WIDTH = 10,
  parameter int INS_WIDTH      = 64,
  parameter int OP_WIDTH       = 4
);
  logic                      start;
  logic [INS_ADDR_WIDTH-1:0] ins_base;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic                      ins_rd_en;
  logic [INS_ADDR_WIDTH-1:0] ins_rd_addr;
  logic [INS_WIDTH-1:0]      ins_rd_data;
  logic                      ab_rd_en;
  logic [ADDR_WIDTH-1:0]     a_rd_addr;
  logic [ADDR_WIDTH-1:0]     b_rd_addr;
  logic [OP_WIDTH-1:0]       pe_op;
  logic                      pe_valid_in;
  logic                      r_wr_en;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;

  modport master (
    input  start, ins_base, ins_rd_data,
    output busy, done, error, ins_rd_en, ins_rd_addr, ab_rd_en, a_rd_addr, b_rd_addr,
           pe_op, pe_valid_in, r_wr_en, r_wr_addr
  );

  modport slave (
    output start, ins_base, ins_rd_data,
    input  busy, done, error, ins_rd_en, ins_rd_addr, ab_rd_en, a_rd_addr, b_rd_addr,
           pe_op, pe_valid_in, r_wr_en, r_wr_addr
  );
endinterface

// File: rtl/simd_sequencer.sv
// Fetches/decodes 64-bit vector instructions, streams A/B read addresses for len cycles,
// and delays the issue strobe/dest address to line up pe_valid_in and R writes.
module simd_sequencer #(
  parameter int ADDR_WIDTH     = 10,
  parameter int INS_ADDR_WIDTH = 10,
  parameter int INS_WIDTH      = 64,
  parameter int OP_WIDTH       = 4,
  parameter int BRAM_RD_LAT    = 1,
  parameter int PE_LAT         = 2
) (
  input  logic              clk,
  input  logic              rst,
  simd_sequencer_if.master  bus
);
  localparam int DLY = BRAM_RD_LAT + PE_LAT;
  localparam int WCW = (BRAM_RD_LAT > 1) ? $clog2(BRAM_RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [WCW-1:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]     r_base_q, r_base_d, a_base_q, a_base_d, b_base_q, b_base_d;
  logic [9:0]                len_q, len_d, idx_q, idx_d;
  logic [OP_WIDTH-1:0]       pe_op_q, pe_op_d;
  logic                      error_q, error_d;
  logic [DLY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [ADDR_WIDTH-1:0]     addr_pipe_q [DLY];
  logic [ADDR_WIDTH-1:0]     addr_pipe_d [DLY];

  logic [3:0] op;
  logic       illegal;
  logic       issue;
  logic       unused_rsvd;

  assign op          = bus.ins_rd_data[63:60];
  assign illegal     = (op >= 4'h6) && (op <= 4'hE);
  assign unused_rsvd = ^bus.ins_rd_data[19:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    r_base_d   = r_base_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    pe_op_d    = pe_op_q;
    error_d    = error_q;
    issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = bus.ins_base;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WCW'(BRAM_RD_LAT - 1)) state_d = S_DECODE;
        else                                      wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_DECODE: begin
        pc_d     = pc_q + 1'b1;
        r_base_d = ADDR_WIDTH'(bus.ins_rd_data[59:50]);
        a_base_d = ADDR_WIDTH'(bus.ins_rd_data[49:40]);
        b_base_d = ADDR_WIDTH'(bus.ins_rd_data[39:30]);
        len_d    = bus.ins_rd_data[29:20];
        idx_d    = '0;
        if (op == 4'hF) begin
          state_d = S_DONE;
        end else if (illegal) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else if (op == 4'h0 || bus.ins_rd_data[29:20] == 10'd0) begin
          state_d = S_FETCH;
        end else begin
          pe_op_d = OP_WIDTH'(op);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (idx_q == len_q - 10'd1) state_d = S_DRAIN;
        else                        idx_d   = idx_q + 10'd1;
      end
      S_DRAIN: begin
        if (vld_pipe_q == '0) state_d = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Destination address rides alongside the issue strobe; zeros flow when idle.
  always_comb begin
    vld_pipe_d     = {vld_pipe_q[DLY-2:0], issue};
    addr_pipe_d[0] = issue ? (r_base_q + ADDR_WIDTH'(idx_q)) : '0;
    for (int i = 1; i < DLY; i++) addr_pipe_d[i] = addr_pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      wait_cnt_q <= '0;
      r_base_q   <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      pe_op_q    <= '0;
      error_q    <= 1'b0;
      vld_pipe_q <= '0;
      for (int i = 0; i < DLY; i++) addr_pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      r_base_q   <= r_base_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      pe_op_q    <= pe_op_d;
      error_q    <= error_d;
      vld_pipe_q <= vld_pipe_d;
      for (int i = 0; i < DLY; i++) addr_pipe_q[i] <= addr_pipe_d[i];
    end
  end

  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.error       = error_q;
  assign bus.ins_rd_en   = (state_q == S_FETCH);
  assign bus.ins_rd_addr = pc_q;
  assign bus.ab_rd_en    = issue;
  assign bus.a_rd_addr   = issue ? (a_base_q + ADDR_WIDTH'(idx_q)) : '0;
  assign bus.b_rd_addr   = issue ? (b_base_q + ADDR_WIDTH'(idx_q)) : '0;
  assign bus.pe_op       = pe_op_q;
  assign bus.pe_valid_in = vld_pipe_q[BRAM_RD_LAT-1];
  assign bus.r_wr_en     = vld_pipe_q[DLY-1];
  assign bus.r_wr_addr   = addr_pipe_q[DLY-1];
endmodule

// File: tb/tb_simd_sequencer.sv
// Directed programs against a behavioural INS BRAM; a negedge monitor pops expected
// fetch/read/write addresses and strobe timings from scoreboard queues.
module tb_simd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_sequencer_if bus ();
  simd_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] ins_mem [1024];
  always @(posedge clk) if (bus.ins_rd_en) bus.ins_rd_data <= ins_mem[bus.ins_rd_addr];

  int tests = 0, fails = 0;
  int cyc = 0;
  int done_cnt = 0, stray_wr = 0, stray_done = 0;
  bit mon_en = 1'b0;
  logic [9:0]  fetch_q [$];
  logic [19:0] ab_q [$];
  logic [9:0]  r_q [$];
  int          tpe_q [$];
  int          tr_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] op, input logic [9:0] r, input logic [9:0] a,
                                     input logic [9:0] b, input logic [9:0] len);
    return {op, r, a, b, len, 20'h0};
  endfunction

  task automatic exp_vec(input logic [9:0] r, input logic [9:0] a, input logic [9:0] b, input int len);
    for (int i = 0; i < len; i++) begin
      ab_q.push_back({a + 10'(i), b + 10'(i)});
      r_q.push_back(r + 10'(i));
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !mon_en) begin
      if (bus.r_wr_en) stray_wr++;
      if (bus.done)    stray_done++;
    end else if (!rst) begin
      if (bus.ins_rd_en) begin
        if (fetch_q.size() == 0) check("unexpected_fetch", bus.ins_rd_addr, 10'h3ff ^ bus.ins_rd_addr);
        else check("fetch_addr", bus.ins_rd_addr, fetch_q.pop_front());
      end
      if (bus.ab_rd_en) begin
        tpe_q.push_back(cyc);
        tr_q.push_back(cyc);
        if (ab_q.size() == 0) check("unexpected_ab_rd", 1, 0);
        else check("ab_rd_addr", {bus.a_rd_addr, bus.b_rd_addr}, ab_q.pop_front());
      end
      if (bus.pe_valid_in) begin
        if (tpe_q.size() == 0) check("unexpected_pe_valid", 1, 0);
        else check("pe_valid_cycle", cyc, tpe_q.pop_front() + 1);
      end
      if (bus.r_wr_en) begin
        if (tr_q.size() == 0 || r_q.size() == 0) check("unexpected_r_wr", 1, 0);
        else begin
          check("r_wr_cycle", cyc, tr_q.pop_front() + 3);
          check("r_wr_addr", bus.r_wr_addr, r_q.pop_front());
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_low_at_done", bus.busy, 0);
      end
    end
  end

  task automatic run(input logic [9:0] base, input logic exp_err, input bit dbl);
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.ins_base = base;
    @(negedge clk);
    bus.start = 1'b0;
    if (dbl) begin
      repeat (4) @(negedge clk);
      check("busy_before_restart", bus.busy, 1);
      bus.start = 1'b1; bus.ins_base = 10'h030;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("error", bus.error, exp_err);
    check("busy_after", bus.busy, 0);
    check("left_ab", ab_q.size(), 0);
    check("left_r", r_q.size(), 0);
    check("left_fetch", fetch_q.size(), 0);
  endtask

  initial begin
    bit hit;
    bus.start = 1'b0; bus.ins_base = '0;
    for (int i = 0; i < 1024; i++) ins_mem[i] = mk(4'hF, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.error, bus.ins_rd_en, bus.ins_rd_addr, bus.ab_rd_en,
          bus.a_rd_addr, bus.b_rd_addr, bus.pe_op, bus.pe_valid_in, bus.r_wr_en, bus.r_wr_addr}, 0);
    rst = 1'b0;

    // 1: reset while the fourth element is issuing
    ins_mem[10'h040] = mk(4'h1, 10'h200, 10'h100, 10'h180, 10'd8);
    @(negedge clk);
    bus.start = 1'b1; bus.ins_base = 10'h040;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (bus.ab_rd_en && bus.a_rd_addr == 10'h103) hit = 1'b1;
    end
    check("reached_issue_i3", hit, 1);
    #1 rst = 1'b1;
    #1 check("outputs_after_rst", {bus.busy, bus.done, bus.error, bus.ins_rd_en, bus.ins_rd_addr, bus.ab_rd_en,
          bus.a_rd_addr, bus.b_rd_addr, bus.pe_op, bus.pe_valid_in, bus.r_wr_en, bus.r_wr_addr}, 0);
    stray_wr = 0; stray_done = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("r_wr_after_rst", stray_wr, 0);
    check("done_after_rst", stray_done, 0);
    mon_en = 1'b1;

    // 2: single ADD then HALT
    ins_mem[0] = mk(4'h1, 10'h020, 10'h000, 10'h010, 10'd4);
    ins_mem[1] = mk(4'hF, 0, 0, 0, 0);
    fetch_q = '{10'h000, 10'h001};
    exp_vec(10'h020, 10'h000, 10'h010, 4);
    run(10'h000, 1'b0, 1'b0);
    check("pe_op_add", bus.pe_op, 4'h1);

    // 3: NOP and zero-length ADD issue nothing
    ins_mem[10'h010] = mk(4'h0, 10'h001, 10'h002, 10'h003, 10'd5);
    ins_mem[10'h011] = mk(4'h1, 10'h001, 10'h002, 10'h003, 10'd0);
    ins_mem[10'h012] = mk(4'hF, 0, 0, 0, 0);
    fetch_q = '{10'h010, 10'h011, 10'h012};
    run(10'h010, 1'b0, 1'b0);

    // 4: illegal opcode, then a clean program clears error
    ins_mem[5] = mk(4'h9, 10'h001, 10'h002, 10'h003, 10'd4);
    fetch_q = '{10'h005};
    run(10'h005, 1'b1, 1'b0);
    ins_mem[1] = mk(4'hF, 0, 0, 0, 0);
    fetch_q = '{10'h001};
    run(10'h001, 1'b0, 1'b0);

    // 5: address and pc wrap
    ins_mem[10'h3FF] = mk(4'h4, 10'h3FD, 10'h3FE, 10'h001, 10'd4);
    ins_mem[0] = mk(4'hF, 0, 0, 0, 0);
    fetch_q = '{10'h3FF, 10'h000};
    ab_q = '{{10'h3FE, 10'h001}, {10'h3FF, 10'h002}, {10'h000, 10'h003}, {10'h001, 10'h004}};
    r_q  = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
    run(10'h3FF, 1'b0, 1'b0);
    check("pe_op_max", bus.pe_op, 4'h4);

    // 6: second start during a run is ignored
    ins_mem[10'h020] = mk(4'h3, 10'h050, 10'h060, 10'h070, 10'd6);
    ins_mem[10'h021] = mk(4'hF, 0, 0, 0, 0);
    ins_mem[10'h030] = mk(4'h2, 10'h111, 10'h122, 10'h133, 10'd2);
    ins_mem[10'h031] = mk(4'hF, 0, 0, 0, 0);
    fetch_q = '{10'h020, 10'h021};
    exp_vec(10'h050, 10'h060, 10'h070, 6);
    run(10'h020, 1'b0, 1'b1);
    check("pe_op_mul", bus.pe_op, 4'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
